// File: rtl/span_writer.sv
// Line-buffer span rasteriser: optional background clear, then span fills one 16-pixel word per cycle.
// Define SPAN_WRITER_CLEAR_EN to enable the background clear pass before span acceptance.
module span_writer #(
  parameter int unsigned CORDW      = 11,
  parameter int unsigned LINE_WORDS = 40
) (
  input  logic             clk_draw,
  input  logic             rst_draw_n,
  input  logic             line_start,
  input  logic [7:0]       bg_colour,
  input  logic             span_valid,
  output logic             span_ready,
  input  logic [CORDW-1:0] span_x0,
  input  logic [CORDW-1:0] span_x1,
  input  logic [7:0]       span_colour,
  input  logic             span_last,
  output logic [6:0]       lb_addr,
  output logic [15:0]      lb_we,
  output logic [127:0]     lb_colour,
  output logic             busy,
  output logic             line_done,
  output logic             overrun
);

  localparam int unsigned LIMIT = LINE_WORDS * 16 - 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCEPT, SPAN, DONE} state_t;

  state_t           state_q;
  logic [7:0]       word_q;
  logic [7:0]       end_q;
  logic [CORDW-1:0] x0_q;
  logic [CORDW-1:0] x1c_q;
  logic [7:0]       colour_q;
  logic             last_q;
  logic [6:0]       lb_addr_q;
  logic [15:0]      lb_we_q;
  logic [127:0]     lb_colour_q;
  logic             line_done_q;
  logic             overrun_q;

  logic [CORDW-1:0] x1c_d;
  logic             discard_d;
  logic [7:0]       start_w_d;
  logic [7:0]       end_w_d;
  logic [7:0]       sel_word_d;
  logic [CORDW-1:0] sel_x0_d;
  logic [CORDW-1:0] sel_x1_d;
  logic [15:0]      mask_d;

`ifndef SPAN_WRITER_CLEAR_EN
  logic unused_bg;
  assign unused_bg = ^bg_colour;
`endif

  // Span decode: clamp to line end, reject empty/off-line spans, and build the pixel mask
  // for the word about to be written (incoming span at handshake, stored span otherwise).
  always_comb begin
    x1c_d      = (32'(span_x1) > LIMIT) ? CORDW'(LIMIT) : span_x1;
    discard_d  = (span_x0 > span_x1) || (32'(span_x0) > LIMIT);
    start_w_d  = 8'(32'(span_x0) >> 4);
    end_w_d    = 8'(32'(x1c_d) >> 4);
    sel_word_d = (state_q == ACCEPT) ? start_w_d : word_q;
    sel_x0_d   = (state_q == ACCEPT) ? span_x0   : x0_q;
    sel_x1_d   = (state_q == ACCEPT) ? x1c_d     : x1c_q;
    mask_d     = '0;
    for (int i = 0; i < 16; i++) begin
      mask_d[i] = ((32'(sel_word_d) * 16 + 32'(i)) >= 32'(sel_x0_d)) &&
                  ((32'(sel_word_d) * 16 + 32'(i)) <= 32'(sel_x1_d));
    end
  end

  always_ff @(posedge clk_draw) begin
    if (!rst_draw_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      end_q       <= '0;
      x0_q        <= '0;
      x1c_q       <= '0;
      colour_q    <= '0;
      last_q      <= 1'b0;
      lb_addr_q   <= '0;
      lb_we_q     <= '0;
      lb_colour_q <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      lb_we_q     <= '0;
      line_done_q <= 1'b0;
      if (line_start && (state_q != IDLE)) overrun_q <= 1'b1;
      // line_start always wins: any in-flight work is dropped
      if (line_start) begin
`ifdef SPAN_WRITER_CLEAR_EN
        state_q     <= CLEAR;
        word_q      <= 8'd1;
        lb_addr_q   <= '0;
        lb_we_q     <= 16'hffff;
        lb_colour_q <= {16{bg_colour}};
`else
        state_q     <= ACCEPT;
`endif
      end else begin
        case (state_q)
          CLEAR: begin
            if (32'(word_q) < LINE_WORDS) begin
              lb_addr_q   <= 7'(word_q);
              lb_we_q     <= 16'hffff;
              lb_colour_q <= {16{bg_colour}};
              word_q      <= word_q + 8'd1;
            end else begin
              state_q <= ACCEPT;
            end
          end
          ACCEPT: begin
            if (span_valid) begin
              last_q <= span_last;
              if (discard_d) begin
                state_q     <= span_last ? DONE : ACCEPT;
                line_done_q <= span_last;
              end else begin
                x0_q        <= span_x0;
                x1c_q       <= x1c_d;
                colour_q    <= span_colour;
                end_q       <= end_w_d;
                word_q      <= start_w_d + 8'd1;
                state_q     <= SPAN;
                lb_addr_q   <= 7'(start_w_d);
                lb_we_q     <= mask_d;
                lb_colour_q <= {16{span_colour}};
              end
            end
          end
          SPAN: begin
            if (word_q > end_q) begin
              state_q     <= last_q ? DONE : ACCEPT;
              line_done_q <= last_q;
            end else begin
              lb_addr_q   <= 7'(word_q);
              lb_we_q     <= mask_d;
              lb_colour_q <= {16{colour_q}};
              word_q      <= word_q + 8'd1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign span_ready = (state_q == ACCEPT);
  assign busy       = (state_q != IDLE);
  assign lb_addr    = lb_addr_q;
  assign lb_we      = lb_we_q;
  assign lb_colour  = lb_colour_q;
  assign line_done  = line_done_q;
  assign overrun    = overrun_q;

endmodule
